commit_trace_buffer: RTL and testbench

Circular capture buffer downstream of the pc_inst_debug register stage. On each registered instruction-valid pulse it stores the committed PC together with a retirement sequence number. It exposes the oldest stored entry through a valid/ready read port for a debug host or testbench scoreboard. It also keeps a free-running retirement counter and a saturating count of dropped entries.

---
 rtl/trace_pkg.sv | 12 +
 rtl/commit_trace_buffer_if.sv | 26 ++
 rtl/trace_ram.sv | 15 +
 rtl/commit_trace_buffer.sv | 60 ++++++
 tb/tb_commit_trace_buffer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared widths, saturation limit and entry layout for the commit trace buffer
// Ports: none (package only).
package trace_pkg;
  localparam int PC_W = 32;
  localparam int OVF_W = 16;
  localparam int CNT_W_DEF = 32;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [CNT_W_DEF-1:0] seq;
  } trace_entry_t;
endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: capture inputs, read handshake and status of the commit trace buffer
// Ports: slave = buffer side (i_* in, o_* out); master = producer/consumer side (reverse).
interface commit_trace_buffer_if #(parameter int DEPTH = 16, parameter int CNT_W = 32);
  import trace_pkg::*;
  logic i_insn_vld;
  logic [PC_W-1:0] i_pc_debug;
  logic i_freeze;
  logic i_clr;
  logic i_rd_rdy;
  logic o_rd_vld;
  logic [PC_W-1:0] o_rd_pc;
  logic [CNT_W-1:0] o_rd_seq;
  logic [$clog2(DEPTH):0] o_level;
  logic o_full;
  logic o_empty;
  logic [CNT_W-1:0] o_retire_cnt;
  logic [OVF_W-1:0] o_ovf_cnt;
  modport slave (
    input i_insn_vld, i_pc_debug, i_freeze, i_clr, i_rd_rdy,
    output o_rd_vld, o_rd_pc, o_rd_seq, o_level, o_full, o_empty, o_retire_cnt, o_ovf_cnt
  );
  modport master (
    output i_insn_vld, i_pc_debug, i_freeze, i_clr, i_rd_rdy,
    input o_rd_vld, o_rd_pc, o_rd_seq, o_level, o_full, o_empty, o_retire_cnt, o_ovf_cnt
  );
endinterface

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W register array, synchronous write, asynchronous read, no reset
// Ports: i_clk, i_we/i_waddr/i_wdata write port, i_raddr/o_rdata combinational read port.
module trace_ram #(parameter int DEPTH = 16, parameter int W = 64) (
  input logic i_clk,
  input logic i_we,
  input logic [$clog2(DEPTH)-1:0] i_waddr,
  input logic [W-1:0] i_wdata,
  input logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0] o_rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: circular capture of committed PCs with retirement sequence numbers
// Ports: i_clk, i_rst (async, active-low), bus (commit_trace_buffer_if.slave): capture inputs,
// first-word fall-through read port, level/full/empty, retirement and saturating overflow counters.
module commit_trace_buffer import trace_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input logic i_clk,
  input logic i_rst,
  commit_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] retire_cnt;
  logic [OVF_W-1:0] ovf_cnt;
  logic [PC_W+CNT_W-1:0] head;
  logic full, empty, pop, req, push, drop;
  // a full buffer still accepts when the head leaves in the same cycle
  always_comb begin
    empty = rd_ptr == wr_ptr;
    full = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    pop = !empty && bus.i_rd_rdy;
    req = bus.i_insn_vld && !bus.i_freeze;
    push = req && (!full || pop);
    drop = req && full && !pop;
  end
  trace_ram #(.DEPTH(DEPTH), .W(PC_W + CNT_W)) u_ram (
    .i_clk(i_clk),
    .i_we(push && !bus.i_clr),
    .i_waddr(wr_ptr[AW-1:0]),
    .i_wdata({bus.i_pc_debug, retire_cnt}),
    .i_raddr(rd_ptr[AW-1:0]),
    .o_rdata(head)
  );
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      retire_cnt <= '0;
      ovf_cnt <= '0;
    end else if (bus.i_clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      retire_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (bus.i_insn_vld) retire_cnt <= retire_cnt + 1'b1;
      if (drop && ovf_cnt != OVF_MAX) ovf_cnt <= ovf_cnt + 1'b1;
    end
  assign bus.o_rd_vld = !empty;
  assign bus.o_rd_pc = empty ? '0 : head[PC_W+CNT_W-1:CNT_W];
  assign bus.o_rd_seq = empty ? '0 : head[CNT_W-1:0];
  assign bus.o_level = wr_ptr - rd_ptr;
  assign bus.o_full = full;
  assign bus.o_empty = empty;
  assign bus.o_retire_cnt = retire_cnt;
  assign bus.o_ovf_cnt = ovf_cnt;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: queue-scoreboard and vector-table bench for commit_trace_buffer
module tb_commit_trace_buffer;
  import trace_pkg::*;
  localparam int DEPTH = 16;
  typedef struct {
    logic vld;
    logic [31:0] pc;
    logic rdy;
    int lvl;
    int ret;
  } vec_t;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int passed = 0;
  int total = 0;
  trace_entry_t q[$];
  int unsigned mret;
  int unsigned movf;
  always #5 i_clk = ~i_clk;
  commit_trace_buffer_if #(.DEPTH(DEPTH), .CNT_W(32)) bus();
  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(32)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask
  task automatic model_reset();
    q.delete();
    mret = 0;
    movf = 0;
  endtask
  task automatic chk_status(input string n);
    chk({n, "_level"}, 64'(bus.o_level), 64'(q.size()));
    chk({n, "_full"}, 64'(bus.o_full), 64'(q.size() == DEPTH));
    chk({n, "_empty"}, 64'(bus.o_empty), 64'(q.size() == 0));
    chk({n, "_retire"}, 64'(bus.o_retire_cnt), 64'(mret));
    chk({n, "_ovf"}, 64'(bus.o_ovf_cnt), 64'(movf));
  endtask
  task automatic step(input logic vld, input logic [31:0] pc, input logic frz, input logic rdy, input logic clr);
    trace_entry_t e;
    logic popm, req, acc;
    bus.i_insn_vld = vld;
    bus.i_pc_debug = pc;
    bus.i_freeze = frz;
    bus.i_rd_rdy = rdy;
    bus.i_clr = clr;
    #1;
    chk("rd_vld", 64'(bus.o_rd_vld), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rd_pc", 64'(bus.o_rd_pc), 64'(q[0].pc));
      chk("rd_seq", 64'(bus.o_rd_seq), 64'(q[0].seq));
    end else begin
      chk("rd_pc_empty", 64'(bus.o_rd_pc), 64'd0);
      chk("rd_seq_empty", 64'(bus.o_rd_seq), 64'd0);
    end
    @(posedge i_clk);
    #1;
    if (clr) model_reset();
    else begin
      popm = (q.size() != 0) && rdy;
      req = vld && !frz;
      acc = req && (q.size() < DEPTH || popm);
      e.pc = pc;
      e.seq = mret;
      if (popm) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (req && !acc && movf != 32'hFFFF) movf++;
      if (vld) mret++;
    end
    chk_status("step");
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[6];
    int unsigned base;
    logic [31:0] s;
    tbl[0] = '{1'b1, 32'h00, 1'b0, 1, 1};
    tbl[1] = '{1'b1, 32'h04, 1'b0, 2, 2};
    tbl[2] = '{1'b1, 32'h08, 1'b0, 3, 3};
    tbl[3] = '{1'b0, 32'h00, 1'b1, 2, 3};
    tbl[4] = '{1'b0, 32'h00, 1'b1, 1, 3};
    tbl[5] = '{1'b0, 32'h00, 1'b1, 0, 3};
    bus.i_insn_vld = 1'b0;
    bus.i_pc_debug = '0;
    bus.i_freeze = 1'b0;
    bus.i_clr = 1'b0;
    bus.i_rd_rdy = 1'b0;
    model_reset();
    #2;
    chk("rst_rd_vld", 64'(bus.o_rd_vld), 64'd0);
    chk("rst_rd_pc", 64'(bus.o_rd_pc), 64'd0);
    chk("rst_rd_seq", 64'(bus.o_rd_seq), 64'd0);
    chk_status("rst");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].vld, tbl[i].pc, 1'b0, tbl[i].rdy, 1'b0);
      chk("tbl_level", 64'(bus.o_level), 64'(tbl[i].lvl));
      chk("tbl_retire", 64'(bus.o_retire_cnt), 64'(tbl[i].ret));
    end
    chk("drained_empty", 64'(bus.o_empty), 64'd1);
    chk("drained_pc", 64'(bus.o_rd_pc), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 64'(bus.o_full), 64'd1);
    chk("fill_level", 64'(bus.o_level), 64'd16);
    chk("fill_ovf", 64'(bus.o_ovf_cnt), 64'd4);
    chk("fill_retire", 64'(bus.o_retire_cnt), 64'd20);
    step(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0);
    chk("fullpop_level", 64'(bus.o_level), 64'd16);
    chk("fullpop_ovf", 64'(bus.o_ovf_cnt), 64'd4);
    s = '0;
    for (int i = 0; i < 16; i++) begin
      s = bus.o_rd_seq;
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    chk("fullpop_last_seq", 64'(s), 64'd20);
    base = mret;
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    chk("frz_retire", 64'(bus.o_retire_cnt), 64'(base + 5));
    chk("frz_level", 64'(bus.o_level), 64'd0);
    chk("frz_ovf", 64'(bus.o_ovf_cnt), 64'd4);
    step(1'b1, 32'h3100, 1'b0, 1'b0, 1'b0);
    chk("unfrz_seq", 64'(bus.o_rd_seq), 64'(base + 5));
    chk("unfrz_pc", 64'(bus.o_rd_pc), 64'h3100);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'h4004 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
      chk("stream_level", 64'(bus.o_level), 64'd1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("preclr_level", 64'(bus.o_level), 64'd7);
    chk("preclr_ovf", 64'(bus.o_ovf_cnt), 64'd2);
    step(1'b1, 32'h5555, 1'b0, 1'b1, 1'b1);
    chk("clr_level", 64'(bus.o_level), 64'd0);
    chk("clr_retire", 64'(bus.o_retire_cnt), 64'd0);
    chk("clr_ovf", 64'(bus.o_ovf_cnt), 64'd0);
    chk("clr_rd_vld", 64'(bus.o_rd_vld), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h6000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    bus.i_insn_vld = 1'b1;
    bus.i_rd_rdy = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    model_reset();
    chk("arst_rd_vld", 64'(bus.o_rd_vld), 64'd0);
    chk("arst_rd_pc", 64'(bus.o_rd_pc), 64'd0);
    chk("arst_rd_seq", 64'(bus.o_rd_seq), 64'd0);
    chk_status("arst");
    @(posedge i_clk);
    #1;
    chk_status("arst_hold");
    i_rst = 1'b1;
    step(1'b1, 32'h7000, 1'b0, 1'b0, 1'b0);
    chk("arst_restart_pc", 64'(bus.o_rd_pc), 64'h7000);
    chk("arst_restart_seq", 64'(bus.o_rd_seq), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
